// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter transmitter.
//   state_t      : transmitter FSM states
//   LETTER_*     : letter index limits (0..25 = A..Z, 31 = blank display)
//   *_UNITS      : element and gap durations in Morse units
//   CODE_TABLE   : {len[2:0], pat[3:0]} per letter; pat is right-aligned,
//                  MSB-first over the len used bits, 1 = dash, 0 = dot
//   elem_is_dash : selects element idx of a right-aligned pattern
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_SPACE = 3'd2,
    ST_LGAP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [4:0] LETTER_MAX   = 5'd25;
  localparam logic [4:0] LETTER_BLANK = 5'd31;

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int ELEM_GAP_UNITS   = 1;
  localparam int LETTER_GAP_UNITS = 3;

  localparam logic [6:0] CODE_TABLE [0:25] = '{
    7'b010_0001,  // A .-
    7'b100_1000,  // B -...
    7'b100_1010,  // C -.-.
    7'b011_0100,  // D -..
    7'b001_0000,  // E .
    7'b100_0010,  // F ..-.
    7'b011_0110,  // G --.
    7'b100_0000,  // H ....
    7'b010_0000,  // I ..
    7'b100_0111,  // J .---
    7'b011_0101,  // K -.-
    7'b100_0100,  // L .-..
    7'b010_0011,  // M --
    7'b010_0010,  // N -.
    7'b011_0111,  // O ---
    7'b100_0110,  // P .--.
    7'b100_1101,  // Q --.-
    7'b011_0010,  // R .-.
    7'b011_0000,  // S ...
    7'b001_0001,  // T -
    7'b011_0001,  // U ..-
    7'b100_0001,  // V ...-
    7'b011_0011,  // W .--
    7'b100_1001,  // X -..-
    7'b100_1011,  // Y -.--
    7'b100_1100   // Z --..
  };

  // Element 0 is the MSB of the len used bits.
  function automatic logic elem_is_dash(input logic [3:0] pat,
                                        input logic [2:0] len,
                                        input logic [2:0] idx);
    logic [1:0] pos;
    pos = 2'(len - idx - 3'd1);
    return pat[pos];
  endfunction

endpackage

// File: rtl/morse_code_rom.sv
// Letter index to Morse code lookup.
//   letter : letter index, 0..25 valid
//   len    : number of elements 1..4, 0 for an invalid index
//   pat    : right-aligned element pattern, 1 = dash
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [4:0] letter,
  output logic [2:0] len,
  output logic [3:0] pat
);

  always_comb begin
    len = 3'd0;
    pat = 4'd0;
    if (letter <= LETTER_MAX) begin
      {len, pat} = CODE_TABLE[letter];
    end
  end

endmodule

// File: rtl/morse_letter_tx.sv
// Plays one letter at a time as timed Morse on a key line.
//   iClk, iRst_n   : clock, synchronous active-low reset
//   iLetter/iValid : letter index offered by upstream
//   oReady         : idle; transfer on iValid && oReady at a rising edge
//   iAbort         : drop the letter in flight and return to idle
//   oTone          : key line, 1 = mark
//   oLetter        : letter being or last sent, 31 = blank
//   oDone / oErr   : one-cycle completion / invalid-letter pulses
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for a letter, oReady = 1
// ST_MARK  | key down for one dot or dash
// ST_SPACE | key up between elements of the same letter
// ST_LGAP  | trailing key-up gap after the last element
// ST_ERR   | single cycle reporting an invalid letter index
module morse_letter_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [4:0] iLetter,
  input  logic       iValid,
  output logic       oReady,
  input  logic       iAbort,
  output logic       oTone,
  output logic [4:0] oLetter,
  output logic       oDone,
  output logic       oErr
);

  localparam int CNT_W = $clog2(3 * UNIT_CYCLES + 1);

  // Down-counter reload values: a state lasting N cycles loads N-1 and
  // leaves on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LGAP_LOAD = CNT_W'(LETTER_GAP_UNITS * UNIT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       len_q;
  logic [3:0]       pat_q;
  logic [2:0]       idx;
  logic [2:0]       rom_len;
  logic [3:0]       rom_pat;
  logic [2:0]       idx_next;

  morse_code_rom u_rom (
    .letter (iLetter),
    .len    (rom_len),
    .pat    (rom_pat)
  );

  assign oReady   = (state == ST_IDLE);
  assign idx_next = idx + 3'd1;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len_q   <= 3'd0;
      pat_q   <= 4'd0;
      idx     <= 3'd0;
      oTone   <= 1'b0;
      oLetter <= LETTER_BLANK;
      oDone   <= 1'b0;
      oErr    <= 1'b0;
    end else begin
      oDone <= 1'b0;
      oErr  <= 1'b0;
      if (state == ST_IDLE) begin
        // iAbort has no effect here, so a simultaneous letter is accepted.
        if (iValid) begin
          if (iLetter > LETTER_MAX) begin
            state <= ST_ERR;
            cnt   <= '0;
            oErr  <= 1'b1;
          end else begin
            state   <= ST_MARK;
            len_q   <= rom_len;
            pat_q   <= rom_pat;
            idx     <= 3'd0;
            oLetter <= iLetter;
            oTone   <= 1'b1;
            cnt     <= elem_is_dash(rom_pat, rom_len, 3'd0) ? DASH_LOAD : DOT_LOAD;
          end
        end
      end else if (iAbort) begin
        state <= ST_IDLE;
        cnt   <= '0;
        oTone <= 1'b0;
      end else begin
        case (state)
          ST_MARK: begin
            if (cnt == '0) begin
              oTone <= 1'b0;
              if (idx_next < len_q) begin
                state <= ST_SPACE;
                cnt   <= GAP_LOAD;
              end else begin
                state <= ST_LGAP;
                cnt   <= LGAP_LOAD;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_SPACE: begin
            if (cnt == '0) begin
              state <= ST_MARK;
              idx   <= idx_next;
              oTone <= 1'b1;
              cnt   <= elem_is_dash(pat_q, len_q, idx_next) ? DASH_LOAD : DOT_LOAD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_LGAP: begin
            if (cnt == '0) begin
              state <= ST_IDLE;
              oDone <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            oTone <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_letter_tx.sv
module tb_morse_letter_tx;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [4:0] iLetter;
  logic       iValid;
  logic       oReady;
  logic       iAbort;
  logic       oTone;
  logic [4:0] oLetter;
  logic       oDone;
  logic       oErr;

  int checks   = 0;
  int failures = 0;

  morse_letter_tx #(.UNIT_CYCLES(4)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iLetter (iLetter),
    .iValid  (iValid),
    .oReady  (oReady),
    .iAbort  (iAbort),
    .oTone   (oTone),
    .oLetter (oLetter),
    .oDone   (oDone),
    .oErr    (oErr)
  );

  always #5 iClk = ~iClk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Offers a letter at a falling edge; the next rising edge is cycle 0.
  task automatic accept(input logic [4:0] l);
    @(negedge iClk);
    iLetter = l;
    iValid  = 1'b1;
    @(posedge iClk);
    #1 iValid = 1'b0;
  endtask

  task automatic test_reset;
    iRst_n = 1'b0;
    @(posedge iClk);
    @(posedge iClk);
    @(negedge iClk);
    checks += 5;
    if (oReady !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", oReady); end
    if (oTone !== 1'b0) begin failures++; $display("FAIL rst_tone got=%b exp=0", oTone); end
    if (oLetter !== 5'd31) begin failures++; $display("FAIL rst_letter got=%0d exp=31", oLetter); end
    if (oDone !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", oDone); end
    if (oErr !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", oErr); end
    iRst_n = 1'b1;
    @(negedge iClk);
  endtask

  task automatic test_letter_e;
    logic et, ed;
    accept(5'd4);
    for (int c = 1; c <= 17; c++) begin
      @(negedge iClk);
      et = (c <= 4);
      ed = (c == 17);
      checks += 4;
      if (oTone !== et) begin failures++; $display("FAIL e_tone c=%0d got=%b exp=%b", c, oTone, et); end
      if (oDone !== ed) begin failures++; $display("FAIL e_done c=%0d got=%b exp=%b", c, oDone, ed); end
      if (oReady !== ed) begin failures++; $display("FAIL e_ready c=%0d got=%b exp=%b", c, oReady, ed); end
      if (oLetter !== 5'd4) begin failures++; $display("FAIL e_letter c=%0d got=%0d exp=4", c, oLetter); end
    end
  endtask

  task automatic test_letter_a;
    logic et, ed;
    accept(5'd0);
    for (int c = 1; c <= 33; c++) begin
      @(negedge iClk);
      et = (c <= 4) || (c >= 9 && c <= 20);
      ed = (c == 33);
      checks += 3;
      if (oTone !== et) begin failures++; $display("FAIL a_tone c=%0d got=%b exp=%b", c, oTone, et); end
      if (oDone !== ed) begin failures++; $display("FAIL a_done c=%0d got=%b exp=%b", c, oDone, ed); end
      if (oLetter !== 5'd0) begin failures++; $display("FAIL a_letter c=%0d got=%0d exp=0", c, oLetter); end
    end
  endtask

  task automatic test_letter_h;
    logic et, ed;
    accept(5'd7);
    for (int c = 1; c <= 41; c++) begin
      @(negedge iClk);
      et = (c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20) || (c >= 25 && c <= 28);
      ed = (c == 41);
      checks += 2;
      if (oTone !== et) begin failures++; $display("FAIL h_tone c=%0d got=%b exp=%b", c, oTone, et); end
      if (oDone !== ed) begin failures++; $display("FAIL h_done c=%0d got=%b exp=%b", c, oDone, ed); end
    end
  endtask

  task automatic test_back_to_back;
    logic et, ed;
    logic [4:0] el;
    @(negedge iClk);
    iLetter = 5'd19;
    iValid  = 1'b1;
    @(posedge iClk);
    for (int c = 1; c <= 42; c++) begin
      @(negedge iClk);
      if (c == 1) iLetter = 5'd4;
      et = (c <= 12) || (c >= 26 && c <= 29);
      ed = (c == 25) || (c == 42);
      el = (c <= 25) ? 5'd19 : 5'd4;
      checks += 4;
      if (oTone !== et) begin failures++; $display("FAIL b2b_tone c=%0d got=%b exp=%b", c, oTone, et); end
      if (oDone !== ed) begin failures++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, oDone, ed); end
      if (oReady !== ed) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, oReady, ed); end
      if (oLetter !== el) begin failures++; $display("FAIL b2b_letter c=%0d got=%0d exp=%0d", c, oLetter, el); end
      if (c == 25) begin
        @(posedge iClk);
        #1 iValid = 1'b0;
      end
    end
  endtask

  task automatic test_invalid;
    logic ee, er;
    accept(5'd27);
    for (int c = 1; c <= 3; c++) begin
      @(negedge iClk);
      ee = (c == 1);
      er = (c >= 2);
      checks += 5;
      if (oErr !== ee) begin failures++; $display("FAIL inv_err c=%0d got=%b exp=%b", c, oErr, ee); end
      if (oReady !== er) begin failures++; $display("FAIL inv_ready c=%0d got=%b exp=%b", c, oReady, er); end
      if (oTone !== 1'b0) begin failures++; $display("FAIL inv_tone c=%0d got=%b exp=0", c, oTone); end
      if (oDone !== 1'b0) begin failures++; $display("FAIL inv_done c=%0d got=%b exp=0", c, oDone); end
      if (oLetter !== 5'd4) begin failures++; $display("FAIL inv_letter c=%0d got=%0d exp=4", c, oLetter); end
    end
  endtask

  task automatic test_abort;
    logic et, er;
    accept(5'd19);
    for (int c = 1; c <= 30; c++) begin
      @(negedge iClk);
      if (c == 6) iAbort = 1'b1;
      if (c == 7) iAbort = 1'b0;
      et = (c <= 6);
      er = (c >= 7);
      checks += 4;
      if (oTone !== et) begin failures++; $display("FAIL abort_tone c=%0d got=%b exp=%b", c, oTone, et); end
      if (oReady !== er) begin failures++; $display("FAIL abort_ready c=%0d got=%b exp=%b", c, oReady, er); end
      if (oDone !== 1'b0) begin failures++; $display("FAIL abort_done c=%0d got=%b exp=0", c, oDone); end
      if (oLetter !== 5'd19) begin failures++; $display("FAIL abort_letter c=%0d got=%0d exp=19", c, oLetter); end
    end
  endtask

  task automatic test_abort_in_idle;
    logic et;
    @(negedge iClk);
    iLetter = 5'd4;
    iValid  = 1'b1;
    iAbort  = 1'b1;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iAbort = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge iClk);
      et = (c <= 4);
      checks += 2;
      if (oTone !== et) begin failures++; $display("FAIL idle_abort_tone c=%0d got=%b exp=%b", c, oTone, et); end
      if (oDone !== (c == 17)) begin failures++; $display("FAIL idle_abort_done c=%0d got=%b", c, oDone); end
    end
  endtask

  task automatic test_reset_midletter;
    logic et, er;
    logic [4:0] el;
    accept(5'd14);
    for (int c = 1; c <= 21; c++) begin
      @(negedge iClk);
      if (c == 19) iRst_n = 1'b0;
      if (c == 21) iRst_n = 1'b1;
      et = (c <= 12) || (c >= 17 && c <= 19);
      er = (c >= 20);
      el = (c <= 19) ? 5'd14 : 5'd31;
      checks += 4;
      if (oTone !== et) begin failures++; $display("FAIL rmid_tone c=%0d got=%b exp=%b", c, oTone, et); end
      if (oReady !== er) begin failures++; $display("FAIL rmid_ready c=%0d got=%b exp=%b", c, oReady, er); end
      if (oLetter !== el) begin failures++; $display("FAIL rmid_letter c=%0d got=%0d exp=%0d", c, oLetter, el); end
      if (oDone !== 1'b0) begin failures++; $display("FAIL rmid_done c=%0d got=%b exp=0", c, oDone); end
    end
    accept(5'd2);
    for (int c = 1; c <= 57; c++) begin
      @(negedge iClk);
      et = (c <= 12) || (c >= 17 && c <= 20) || (c >= 25 && c <= 36) || (c >= 41 && c <= 44);
      checks += 3;
      if (oTone !== et) begin failures++; $display("FAIL c_tone c=%0d got=%b exp=%b", c, oTone, et); end
      if (oDone !== (c == 57)) begin failures++; $display("FAIL c_done c=%0d got=%b", c, oDone); end
      if (oLetter !== 5'd2) begin failures++; $display("FAIL c_letter c=%0d got=%0d exp=2", c, oLetter); end
    end
  endtask

  initial begin
    iRst_n  = 1'b0;
    iLetter = 5'd0;
    iValid  = 1'b0;
    iAbort  = 1'b0;
    test_reset();
    test_letter_e();
    test_letter_a();
    test_letter_h();
    test_back_to_back();
    test_invalid();
    test_abort();
    test_abort_in_idle();
    test_reset_midletter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
